// File: rtl/switch_pre_pkg.sv
// Shared cell-format constants for the ingress packer and egress unpacker.
package switch_pre_pkg;

    localparam int CELL_BYTES     = 64;
    localparam int BEAT_BYTES     = 16;
    localparam int BEATS_PER_CELL = CELL_BYTES / BEAT_BYTES;

    // Cell header: byte0 = {len[11:8], portmap}, byte1 = len[7:0]
    localparam int HDR_BYTES      = 2;
    localparam int HDR_LEN_HI_OFS = 0;
    localparam int HDR_LEN_LO_OFS = 1;

    // Bit positions of the per-beat cell flags in a 2-bit flag vector
    localparam int FLAG_LAST_BIT  = 0;
    localparam int FLAG_FIRST_BIT = 1;

    localparam int LEN_W          = 12;
    localparam int BEAT_CNT_W     = 9;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PTR,
        ST_WAIT,
        ST_FILL,
        ST_EMIT,
        ST_DROP
    } pre_state_e;

    // Beats needed for a frame of len bytes (header included), whole cells only
    function automatic logic [BEAT_CNT_W-1:0] cell_beats(input logic [LEN_W-1:0] len);
        cell_beats = {1'b0, len[11:6], 2'b00} + ((len[5:0] != 6'd0) ? 9'd4 : 9'd0);
    endfunction

endpackage

// File: rtl/switch_pre_beat_pack.sv
// Byte-to-beat assembler: 16-byte shift register fed one byte per cycle from the
// data FIFO (1-cycle read latency), substituting zero pad once the frame length is reached.
module switch_pre_beat_pack
    import switch_pre_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             hdr_load,
    input  logic [7:0]       hdr_b0,
    input  logic [7:0]       hdr_b1,
    input  logic [LEN_W-1:0] frame_len,
    input  logic             fill_en,
    input  logic             beat_ack,
    input  logic [7:0]       data_byte,
    output logic             data_rd,
    output logic             beat_done,
    output logic             beat_valid,
    output logic [127:0]     beat_data
);

    localparam int PW = LEN_W + 1;

    logic [127:0]  shreg_q, shreg_d;
    logic [4:0]    slot_cnt_q, slot_cnt_d;
    logic [4:0]    issue_cnt_q, issue_cnt_d;
    logic [PW-1:0] pos_q, pos_d;
    logic          vld_q, vld_d;
    logic          pad_q, pad_d;
    logic          issue;

    // Issue one byte slot per cycle (read or pad), shift in what returns a cycle later
    always_comb begin
        issue       = fill_en && (issue_cnt_q < 5'(BEAT_BYTES));
        data_rd     = issue && (pos_q < {1'b0, frame_len});
        vld_d       = issue;
        pad_d       = issue && !data_rd;
        pos_d       = pos_q;
        issue_cnt_d = issue_cnt_q;
        slot_cnt_d  = slot_cnt_q;
        shreg_d     = shreg_q;
        if (hdr_load) begin
            // header lands in the low bytes and reaches byte0 after 14 shifts
            pos_d       = PW'(HDR_BYTES);
            issue_cnt_d = 5'(HDR_BYTES);
            slot_cnt_d  = 5'(HDR_BYTES);
            shreg_d     = {112'b0, hdr_b0, hdr_b1};
        end else begin
            if (issue) begin
                pos_d       = pos_q + PW'(1);
                issue_cnt_d = issue_cnt_q + 5'd1;
            end
            if (beat_ack) begin
                issue_cnt_d = 5'd0;
                slot_cnt_d  = 5'd0;
            end
            if (vld_q) begin
                slot_cnt_d = slot_cnt_q + 5'd1;
                shreg_d    = {shreg_q[119:0], (pad_q ? 8'h00 : data_byte)};
            end
        end
    end

    assign beat_done  = vld_q && (slot_cnt_q == 5'(BEAT_BYTES - 1));
    assign beat_valid = (slot_cnt_q == 5'(BEAT_BYTES));
    assign beat_data  = shreg_q;

    // Pack state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg_q     <= '0;
            slot_cnt_q  <= '0;
            issue_cnt_q <= '0;
            pos_q       <= '0;
            vld_q       <= 1'b0;
            pad_q       <= 1'b0;
        end else begin
            shreg_q     <= shreg_d;
            slot_cnt_q  <= slot_cnt_d;
            issue_cnt_q <= issue_cnt_d;
            pos_q       <= pos_d;
            vld_q       <= vld_d;
            pad_q       <= pad_d;
        end
    end

endmodule

// File: rtl/switch_pre.sv
// Ingress packer: reads a length pointer and payload bytes, prepends the 2-byte cell
// header, pads to whole 64-byte cells and writes 128-bit beats to the switch core.
//
//   state | meaning
//   IDLE  | waiting for a pointer entry
//   PTR   | pointer data valid; length check, header load
//   WAIT  | cell boundary; hold while the cell FIFO is almost full
//   FILL  | assembling 16 bytes of the current beat
//   EMIT  | writing the assembled beat
//   DROP  | discarding the payload of an out-of-range frame
module switch_pre
    import switch_pre_pkg::*;
#(
    parameter int MIN_LEN = 60,
    parameter int MAX_LEN = 1518
) (
    input  logic         clk,
    input  logic         rst,
    output logic         ptr_fifo_rd,
    input  logic [15:0]  ptr_fifo_dout,
    input  logic         ptr_fifo_empty,
    output logic         data_fifo_rd,
    input  logic [7:0]   data_fifo_dout,
    output logic         i_cell_data_fifo_wr,
    output logic [127:0] i_cell_data_fifo_din,
    output logic         i_cell_data_first,
    output logic         i_cell_data_last,
    input  logic         i_cell_data_fifo_bp
);

    localparam logic [LEN_W-1:0] MIN_N = LEN_W'(MIN_LEN);
    localparam logic [LEN_W-1:0] MAX_N = LEN_W'(MAX_LEN);

    pre_state_e              state_q, state_d;
    logic [LEN_W-1:0]        len_q, len_d;
    logic [BEAT_CNT_W-1:0]   beat_total_q, beat_total_d;
    logic [BEAT_CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic [LEN_W-1:0]        drop_cnt_q, drop_cnt_d;

    logic [LEN_W-1:0]        ptr_n;
    logic [LEN_W-1:0]        ptr_len;
    logic                    len_ok;
    logic                    last_beat;
    logic                    hdr_load, fill_en, beat_ack, drop_rd;
    logic                    pack_rd, beat_done, beat_valid;
    logic [127:0]            beat_data;
    logic [1:0]              flags;

    assign ptr_n     = ptr_fifo_dout[11:0];
    assign ptr_len   = ptr_n + 12'd2;
    assign len_ok    = (ptr_n >= MIN_N) && (ptr_n <= MAX_N);
    assign last_beat = (beat_cnt_q == beat_total_q - 9'd1);

    // Next-state and control decode
    always_comb begin
        state_d             = state_q;
        len_d               = len_q;
        beat_total_d        = beat_total_q;
        beat_cnt_d          = beat_cnt_q;
        drop_cnt_d          = drop_cnt_q;
        ptr_fifo_rd         = 1'b0;
        hdr_load            = 1'b0;
        fill_en             = 1'b0;
        beat_ack            = 1'b0;
        drop_rd             = 1'b0;
        i_cell_data_fifo_wr = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!ptr_fifo_empty) begin
                    ptr_fifo_rd = 1'b1;
                    state_d     = ST_PTR;
                end
            end
            ST_PTR: begin
                if (len_ok) begin
                    len_d        = ptr_len;
                    beat_total_d = cell_beats(ptr_len);
                    beat_cnt_d   = '0;
                    hdr_load     = 1'b1;
                    state_d      = ST_WAIT;
                end else begin
                    drop_cnt_d = ptr_n;
                    state_d    = ST_DROP;
                end
            end
            ST_WAIT: begin
                if (!i_cell_data_fifo_bp) state_d = ST_FILL;
            end
            ST_FILL: begin
                fill_en = 1'b1;
                if (beat_done) state_d = ST_EMIT;
            end
            ST_EMIT: begin
                i_cell_data_fifo_wr = beat_valid;
                beat_ack            = 1'b1;
                beat_cnt_d          = beat_cnt_q + 9'd1;
                if (last_beat)                     state_d = ST_IDLE;
                else if (beat_cnt_q[1:0] == 2'd3)  state_d = ST_WAIT;
                else                               state_d = ST_FILL;
            end
            ST_DROP: begin
                if (drop_cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    drop_rd    = 1'b1;
                    drop_cnt_d = drop_cnt_q - 12'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Flag vector shared in layout with the egress side
    always_comb begin
        flags                 = 2'b00;
        flags[FLAG_FIRST_BIT] = i_cell_data_fifo_wr && (beat_cnt_q == '0);
        flags[FLAG_LAST_BIT]  = i_cell_data_fifo_wr && last_beat;
    end

    assign i_cell_data_first    = flags[FLAG_FIRST_BIT];
    assign i_cell_data_last     = flags[FLAG_LAST_BIT];
    assign i_cell_data_fifo_din = i_cell_data_fifo_wr ? beat_data : '0;
    assign data_fifo_rd         = pack_rd | drop_rd;

    switch_pre_beat_pack u_beat_pack (
        .clk        (clk),
        .rst        (rst),
        .hdr_load   (hdr_load),
        .hdr_b0     ({ptr_len[11:8], ptr_fifo_dout[15:12]}),
        .hdr_b1     (ptr_len[7:0]),
        .frame_len  (len_q),
        .fill_en    (fill_en),
        .beat_ack   (beat_ack),
        .data_byte  (data_fifo_dout),
        .data_rd    (pack_rd),
        .beat_done  (beat_done),
        .beat_valid (beat_valid),
        .beat_data  (beat_data)
    );

    // FSM and frame counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            len_q        <= '0;
            beat_total_q <= '0;
            beat_cnt_q   <= '0;
            drop_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            beat_total_q <= beat_total_d;
            beat_cnt_q   <= beat_cnt_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

endmodule

// File: tb/tb_switch_pre.sv
// Directed bench for switch_pre with FIFO models and a beat scoreboard.
module tb_switch_pre;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         ptr_fifo_rd;
    logic [15:0]  ptr_fifo_dout = '0;
    logic         ptr_fifo_empty = 1'b1;
    logic         data_fifo_rd;
    logic [7:0]   data_fifo_dout = '0;
    logic         i_cell_data_fifo_wr;
    logic [127:0] i_cell_data_fifo_din;
    logic         i_cell_data_first;
    logic         i_cell_data_last;
    logic         i_cell_data_fifo_bp = 1'b0;

    typedef struct packed {
        logic [127:0] data;
        logic         first;
        logic         last;
    } beat_t;

    logic [15:0]  ptr_q[$];
    logic [7:0]   data_q[$];
    beat_t        exp_q[$];

    int           n_vec = 0;
    int           n_err = 0;
    int           wr_cnt = 0;
    int           pops = 0;
    logic [127:0] first_data = '0;

    always #5 clk = ~clk;

    switch_pre dut (
        .clk                  (clk),
        .rst                  (rst),
        .ptr_fifo_rd          (ptr_fifo_rd),
        .ptr_fifo_dout        (ptr_fifo_dout),
        .ptr_fifo_empty       (ptr_fifo_empty),
        .data_fifo_rd         (data_fifo_rd),
        .data_fifo_dout       (data_fifo_dout),
        .i_cell_data_fifo_wr  (i_cell_data_fifo_wr),
        .i_cell_data_fifo_din (i_cell_data_fifo_din),
        .i_cell_data_first    (i_cell_data_first),
        .i_cell_data_last     (i_cell_data_last),
        .i_cell_data_fifo_bp  (i_cell_data_fifo_bp)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] pay_byte(input int seed, input int i);
        return 8'(seed * 37 + i * 11 + (i >> 4) + 1);
    endfunction

    // Queue a frame into the FIFO models and its expected beats into the scoreboard
    task automatic push_frame(input int n, input logic [3:0] pm, input int seed);
        logic [11:0] len;
        logic [7:0]  b[$];
        int          total;
        beat_t       e;
        for (int i = 0; i < n; i++) data_q.push_back(pay_byte(seed, i));
        ptr_q.push_back({pm, 12'(n)});
        ptr_fifo_empty = 1'b0;
        if (n >= 60 && n <= 1518) begin
            len   = 12'(n + 2);
            total = ((n + 2 + 63) / 64) * 64;
            for (int i = 0; i < total; i++) begin
                if (i == 0)               b.push_back({len[11:8], pm});
                else if (i == 1)          b.push_back(len[7:0]);
                else if (i < n + 2)       b.push_back(pay_byte(seed, i - 2));
                else                      b.push_back(8'h00);
            end
            for (int j = 0; j < total / 16; j++) begin
                e.data = '0;
                for (int k = 0; k < 16; k++) e.data[127 - 8 * k -: 8] = b[16 * j + k];
                e.first = (j == 0);
                e.last  = (j == total / 16 - 1);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic drain(input string tag, input int budget);
        int c = 0;
        while ((exp_q.size() != 0 || ptr_q.size() != 0 || data_q.size() != 0) && c < budget) begin
            @(posedge clk);
            c++;
        end
        repeat (4) @(posedge clk);
        #1;
        check({tag, "_timeout"}, 128'(c >= budget), 0);
    endtask

    task automatic wait_beats(input int base, input int target, input int budget);
        int c = 0;
        while (wr_cnt - base < target && c < budget) begin
            @(posedge clk);
            #1;
            c++;
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_wr"},    i_cell_data_fifo_wr,  0);
        check({tag, "_first"}, i_cell_data_first,    0);
        check({tag, "_last"},  i_cell_data_last,     0);
        check({tag, "_prd"},   ptr_fifo_rd,          0);
        check({tag, "_drd"},   data_fifo_rd,         0);
        check({tag, "_din"},   i_cell_data_fifo_din, 0);
    endtask

    // FIFO models: pop requested in a cycle, data presented in the following cycle
    initial begin
        logic prd, drd;
        forever begin
            @(negedge clk);
            prd = ptr_fifo_rd;
            drd = data_fifo_rd;
            @(posedge clk);
            #1;
            if (!rst) begin
                if (prd) begin
                    check("ptr_underflow", 128'(ptr_q.size() == 0), 0);
                    if (ptr_q.size() > 0) ptr_fifo_dout = ptr_q.pop_front();
                end
                if (drd) begin
                    check("data_underflow", 128'(data_q.size() == 0), 0);
                    if (data_q.size() > 0) data_fifo_dout = data_q.pop_front();
                    pops++;
                end
                ptr_fifo_empty = (ptr_q.size() == 0);
            end
        end
    end

    // Beat monitor against the scoreboard
    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            if (i_cell_data_fifo_wr) begin
                wr_cnt++;
                if (i_cell_data_first) first_data = i_cell_data_fifo_din;
                if (exp_q.size() == 0) begin
                    check("unexpected_wr", i_cell_data_fifo_wr, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_data",  i_cell_data_fifo_din, e.data);
                    check("beat_first", i_cell_data_first,    e.first);
                    check("beat_last",  i_cell_data_last,     e.last);
                end
            end
        end
    end

    initial begin
        int base;
        int pbase;

        #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b0;

        // N=60, portmap 5: one cell, 2 pad bytes
        base = wr_cnt;
        push_frame(60, 4'h5, 1);
        drain("n60", 4000);
        check("n60_beats", 128'(wr_cnt - base), 4);
        check("n60_hdr", first_data[127:112], 16'h053E);
        check("n60_pay0", first_data[111:104], pay_byte(1, 0));

        // N=62: exact cell, FIFOs drained
        base = wr_cnt;
        push_frame(62, 4'h1, 2);
        drain("n62", 4000);
        check("n62_beats", 128'(wr_cnt - base), 4);
        check("n62_ptr_empty", ptr_fifo_empty, 1);
        check("n62_data_left", 128'(data_q.size()), 0);

        // N=63: spills one byte into a second cell
        base = wr_cnt;
        push_frame(63, 4'hC, 3);
        drain("n63", 4000);
        check("n63_beats", 128'(wr_cnt - base), 8);

        // Out-of-range lengths are popped and discarded
        base  = wr_cnt;
        pbase = pops;
        push_frame(0, 4'h2, 4);
        push_frame(59, 4'h2, 5);
        push_frame(1519, 4'h2, 6);
        drain("drop", 6000);
        check("drop_beats", 128'(wr_cnt - base), 0);
        check("drop_pops", 128'(pops - pbase), 0 + 59 + 1519);

        // N=1518: largest accepted frame
        base = wr_cnt;
        push_frame(1518, 4'h7, 7);
        drain("n1518", 6000);
        check("n1518_beats", 128'(wr_cnt - base), 96);

        // N=1514 with backpressure raised after beat 10
        base = wr_cnt;
        push_frame(1514, 4'hA, 8);
        wait_beats(base, 11, 3000);
        i_cell_data_fifo_bp = 1'b1;
        check("bp_at_beat10", 128'(wr_cnt - base), 11);
        wait_beats(base, 12, 200);
        check("bp_cell_end", 128'(wr_cnt - base), 12);
        repeat (60) @(posedge clk);
        @(negedge clk);
        check("bp_stall_cnt", 128'(wr_cnt - base), 12);
        check("bp_stall_wr", i_cell_data_fifo_wr, 0);
        i_cell_data_fifo_bp = 1'b0;
        drain("bp", 6000);
        check("bp_beats", 128'(wr_cnt - base), 96);

        // N=20 (dropped) followed by N=60
        base  = wr_cnt;
        pbase = pops;
        push_frame(20, 4'h9, 10);
        push_frame(60, 4'h3, 11);
        drain("b2b", 4000);
        check("b2b_beats", 128'(wr_cnt - base), 4);
        check("b2b_pops", 128'(pops - pbase), 80);
        check("b2b_hdr", first_data[127:112], 16'h033E);
        check("b2b_pay0", first_data[111:104], pay_byte(11, 0));

        // Reset while beat 2 of a frame is being filled
        base = wr_cnt;
        push_frame(60, 4'h6, 12);
        wait_beats(base, 2, 2000);
        check("rst_reach_beat2", 128'(wr_cnt - base), 2);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_idle_outputs("midrst");
        exp_q.delete();
        ptr_q.delete();
        data_q.delete();
        ptr_fifo_empty = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        base = wr_cnt;
        repeat (30) @(posedge clk);
        #1;
        check("rst_no_wr", 128'(wr_cnt - base), 0);
        push_frame(100, 4'hE, 13);
        drain("post_rst", 4000);
        check("post_rst_beats", 128'(wr_cnt - base), 8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
